instr_encoder_loader: RTL
=========================

// Module: instr_encoder_loader
// PURPOSE
//  Encoder side of the main control decoder: turns operation requests (op select + register/immediate fields)
//  into 32-bit instruction words using the same opcode map, buffers them, and writes them sequentially
//  into instruction memory. Used by the bench/boot path to load programs before the datapath runs.
// PARAMETERS
//  DEPTH      4        encoded-word FIFO entries (power of 2, >=2)
//  MEM_WORDS  256      instruction-memory capacity in words; loader never writes beyond it
//  BASE_ADDR  32'h0    byte address of first word written
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   asynchronous, active-high
//  clear      in   1   sync: flush FIFO, word index->0, clear err/full (ignored while reset)
//  in_valid   in   1   request valid
//  in_ready   out  1   request accepted when in_valid&in_ready at clk edge
//  in_op      in   4   0 R,1 lw,2 sw,3 beq,4 bltz,5 nori,6 bz,7 jspal,8 j, 9-15 illegal
//  in_rs/in_rt/in_rd in 5 register fields
//  in_shamt   in   5   R-format shamt;  in_funct in 6 R-format funct
//  in_imm     in   26  [15:0] immediate for I-format; [25:0] target for j
//  im_we      out  1   instruction-memory write strobe (one word per cycle)
//  im_addr    out  32  byte address = BASE_ADDR + 4*word_index
//  im_wdata   out  32  encoded instruction
//  word_count out  $clog2(MEM_WORDS)+1  words written to memory so far
//  busy       out  1   FIFO non-empty
//  full       out  1   MEM_WORDS words accepted; sticky until clear/reset
//  err        out  1   sticky: illegal in_op was accepted
// BEHAVIOUR
//  Reset: in_ready=0 during reset then 1, im_we=0, im_addr=BASE_ADDR, im_wdata=0, word_count=0, busy/full/err=0.
//  Opcodes[31:26]: R 000000, lw 100011, sw 101011, beq 000100, bltz 000001, nori 001101, bz 011000,
//   jspal 010011, j 000010.
//  Formats: R = op|rs|rt|rd|shamt|funct; I (lw,sw,beq,nori) = op|rs|rt|imm[15:0];
//   bltz,bz,jspal = I-format with rt forced 5'b0; j = op|imm[25:0].
//  Encoding is combinational on the request; the word is pushed into the FIFO on the accepting edge.
//  Illegal op: handshake completes, nothing pushed, err set; accepted count unchanged.
//  in_ready = !reset & FIFO not full & accepted_count < MEM_WORDS (registered state only; no same-cycle
//   pop-to-push bypass when FIFO full).
//  Write port: when FIFO non-empty, im_we=1 with head word and current address; pop and increment
//   word_index on that edge. Latency: request accepted at edge N -> im_we high in cycle after edge N,
//   earliest; throughput 1 word/cycle sustained.
//  full asserts on the edge where accepted_count reaches MEM_WORDS; remaining FIFO words still drain;
//   word_index never exceeds MEM_WORDS-1 for an asserted im_we.
//  Simultaneous push+pop: both occur, FIFO occupancy unchanged. Pointers wrap modulo DEPTH.
//  clear with in_valid: clear wins, request not accepted (in_ready=0 that cycle), im_we forced 0.
//  Reset mid-load: all state lost asynchronously, buffered words discarded, no further im_we.
// STRUCTURE
//  Shared package: opcode localparams (OP_RTYPE..OP_J), op-select enum codes 0-8, format field positions.
//  One sub-module: encoder_fifo (DEPTH x 32, push/pop/full/empty/count, async reset, sync flush).
//  Top: combinational encoder, accepted/word counters, sticky flags.
// TESTING
//  1 reset, then lw rs=2 rt=3 imm=16'h0010 -> im_we next cycle, im_wdata=32'h8C430010, im_addr=BASE_ADDR.
//  2 back-to-back R(rs1,rt2,rd3,funct 6'h20), nori(rs4,rt5,imm FFFF), j(imm 26'h0000040) ->
//    words 32'h00221820, 32'h3485FFFF, 32'h08000040 at addrs 0,4,8, one per cycle, word_count=3.
//  3 bltz rs=7 rt=9 imm=8 -> rt zeroed: 32'h04E00008; in_op=12 -> err=1, no write, count unchanged.
//  4 MEM_WORDS=4, offer 6 valid requests -> exactly 4 accepted, full=1, in_ready=0, addrs 0..12 only.
//  5 hold im path stalled by flooding with DEPTH=2 -> in_ready drops when FIFO full, no word lost/duplicated.
//  6 assert reset with 2 words buffered -> im_we=0 immediately, outputs at reset values; clear behaves likewise
//    synchronously and next accepted word writes BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader_pkg.sv
// Opcode map, op-select codes and field packers shared by the instruction encoder/loader.
package instr_encoder_loader_pkg;

  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_NORI  = 6'b001101;
  localparam logic [5:0] OP_BZ    = 6'b011000;
  localparam logic [5:0] OP_JSPAL = 6'b010011;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int OP_LSB  = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int SH_LSB  = 6;
  localparam int FN_LSB  = 0;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    SEL_R     = 4'd0,
    SEL_LW    = 4'd1,
    SEL_SW    = 4'd2,
    SEL_BEQ   = 4'd3,
    SEL_BLTZ  = 4'd4,
    SEL_NORI  = 4'd5,
    SEL_BZ    = 4'd6,
    SEL_JSPAL = 4'd7,
    SEL_J     = 4'd8
  } op_sel_e;

  function automatic logic [INSTR_W-1:0] pack_r(input logic [5:0] op, input logic [4:0] rs,
                                                input logic [4:0] rt, input logic [4:0] rd,
                                                input logic [4:0] sh, input logic [5:0] fn);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_LSB +: 6] = op;
    w[RS_LSB +: 5] = rs;
    w[RT_LSB +: 5] = rt;
    w[RD_LSB +: 5] = rd;
    w[SH_LSB +: 5] = sh;
    w[FN_LSB +: 6] = fn;
    return w;
  endfunction

  function automatic logic [INSTR_W-1:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                                input logic [4:0] rt, input logic [15:0] imm);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_LSB +: 6]   = op;
    w[RS_LSB +: 5]   = rs;
    w[RT_LSB +: 5]   = rt;
    w[IMM_LSB +: 16] = imm;
    return w;
  endfunction

  function automatic logic [INSTR_W-1:0] pack_j(input logic [5:0] op, input logic [25:0] tgt);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_LSB +: 6]   = op;
    w[IMM_LSB +: 26] = tgt;
    return w;
  endfunction

endpackage

// File: rtl/instr_encoder_loader_fifo.sv
// Circular buffer of encoded instruction words; control is async-reset, storage is not reset.
module encoder_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_push_ok = i_push && !o_full && !i_flush;
  assign w_pop_ok  = i_pop && !o_empty && !i_flush;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes op requests into 32-bit instructions, buffers them and streams them into instruction memory.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_op,
  input  logic [4:0]                   in_rs,
  input  logic [4:0]                   in_rt,
  input  logic [4:0]                   in_rd,
  input  logic [4:0]                   in_shamt,
  input  logic [5:0]                   in_funct,
  input  logic [25:0]                  in_imm,
  output logic                         im_we,
  output logic [31:0]                  im_addr,
  output logic [31:0]                  im_wdata,
  output logic [$clog2(MEM_WORDS):0]   word_count,
  output logic                         busy,
  output logic                         full,
  output logic                         err
);

  localparam int              CW      = $clog2(MEM_WORDS) + 1;
  localparam logic [CW-1:0]   MEM_LIM = CW'(MEM_WORDS);

  logic [CW-1:0]            r_acc_cnt;
  logic [CW-1:0]            r_widx;
  logic                     r_full;
  logic                     r_err;
  logic [INSTR_W-1:0]       w_word;
  logic [INSTR_W-1:0]       w_head;
  logic                     w_legal;
  logic                     w_ready;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_fifo_full;
  logic                     w_fifo_empty;
  logic [$clog2(DEPTH):0]   w_fifo_count;

  always_comb begin
    w_word = '0;
    case (in_op)
      SEL_R:     w_word = pack_r(OP_RTYPE, in_rs, in_rt, in_rd, in_shamt, in_funct);
      SEL_LW:    w_word = pack_i(OP_LW,    in_rs, in_rt, in_imm[15:0]);
      SEL_SW:    w_word = pack_i(OP_SW,    in_rs, in_rt, in_imm[15:0]);
      SEL_BEQ:   w_word = pack_i(OP_BEQ,   in_rs, in_rt, in_imm[15:0]);
      SEL_NORI:  w_word = pack_i(OP_NORI,  in_rs, in_rt, in_imm[15:0]);
      SEL_BLTZ:  w_word = pack_i(OP_BLTZ,  in_rs, 5'd0,  in_imm[15:0]);
      SEL_BZ:    w_word = pack_i(OP_BZ,    in_rs, 5'd0,  in_imm[15:0]);
      SEL_JSPAL: w_word = pack_i(OP_JSPAL, in_rs, 5'd0,  in_imm[15:0]);
      SEL_J:     w_word = pack_j(OP_J,     in_imm);
      default:   w_word = '0;
    endcase
  end

  // Ready depends only on registered state, so a pop cannot free a slot for a same-cycle push.
  assign w_legal  = (in_op <= 4'd8);
  assign w_ready  = !reset && !clear && !w_fifo_full && (r_acc_cnt < MEM_LIM);
  assign w_accept = in_valid && w_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = !w_fifo_empty && !clear;

  encoder_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (INSTR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_word),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc_cnt <= '0;
      r_widx    <= '0;
      r_full    <= 1'b0;
      r_err     <= 1'b0;
    end else if (clear) begin
      r_acc_cnt <= '0;
      r_widx    <= '0;
      r_full    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_push) begin
        r_acc_cnt <= r_acc_cnt + CW'(1);
        if (r_acc_cnt == MEM_LIM - CW'(1)) r_full <= 1'b1;
      end
      if (w_accept && !w_legal) r_err <= 1'b1;
      if (w_pop) r_widx <= r_widx + CW'(1);
    end
  end

  assign in_ready   = w_ready;
  assign im_we      = w_pop;
  assign im_wdata   = w_pop ? w_head : '0;
  assign im_addr    = BASE_ADDR + (32'(r_widx) << 2);
  assign word_count = r_widx;
  assign busy       = (w_fifo_count != '0);
  assign full       = r_full;
  assign err        = r_err;

endmodule
